// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one bit-serial full adder among NUM_REQ requesters.
// Optional signed-overflow output enabled by defining SERIAL_ADD_SCHED_OVF_EN.
//
// state | meaning
// IDLE  | arbitrating; req_ready asserted for the granted requester
// SHIFT | one operand bit per cycle through the shared full adder
// DONE  | response valid and held until rsp_ready
module serial_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]         req_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_cout,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
`ifdef SERIAL_ADD_SCHED_OVF_EN
    output logic                       rsp_ovf,
`endif
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_idx;
    logic             grant_vld;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_cin;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic             carry, carry_nx, s_bit;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        op_cin = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                op_a   = req_a[i*WIDTH +: WIDTH];
                op_b   = req_b[i*WIDTH +: WIDTH];
                op_cin = req_cin[i];
            end
        end
    end

    assign accept    = (state == IDLE) && grant_vld && !rst;
    assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign busy      = (state != IDLE);

    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Sum bits arrive LSB first, so each new bit enters at the MSB.
    always_comb begin
        sum_nx           = sum_sh >> 1;
        sum_nx[WIDTH-1]  = s_bit;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (last_bit) state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= IDW'(NUM_REQ - 1);
            cnt       <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
`ifdef SERIAL_ADD_SCHED_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh   <= op_a;
                        b_sh   <= op_b;
                        carry  <= op_cin;
                        sum_sh <= '0;
                        rsp_id <= grant_idx;
                        rr_ptr <= grant_idx;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_nx;
                    sum_sh <= sum_nx;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        rsp_sum   <= sum_nx;
                        rsp_cout  <= carry_nx;
                        rsp_valid <= 1'b1;
`ifdef SERIAL_ADD_SCHED_OVF_EN
                        // carry still holds the carry into the MSB here
                        rsp_ovf   <= carry ^ carry_nx;
`endif
                    end
                end
                DONE: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Self-checking bench for serial_add_scheduler: directed scenarios plus randomized
// traffic compared against a transaction-level round-robin / arithmetic model.
module tb_serial_add_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int IDW     = $clog2(NUM_REQ);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_cin;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_cout;
    logic [IDW-1:0]           rsp_id;
    logic                     busy;
`ifdef SERIAL_ADD_SCHED_OVF_EN
    logic                     rsp_ovf;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    serial_add_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
`ifdef SERIAL_ADD_SCHED_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_lane(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[i]              = c;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    // Drives one operation from a sole requester (DUT must be idle) and returns what came back.
    task automatic run_one(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c, output logic [WIDTH-1:0] s, output logic co,
                           output logic ov, output logic [IDW-1:0] id, output int lat);
        req_valid = '0;
        set_lane(i, a, b, c);
        req_valid[i] = 1'b1;
        #1;
        tick();
        req_valid = '0;
        wait_rsp(lat);
        s  = rsp_sum;
        co = rsp_cout;
        id = rsp_id;
`ifdef SERIAL_ADD_SCHED_OVF_EN
        ov = rsp_ovf;
`else
        ov = 1'b0;
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        req_a = '1; req_b = '1; req_cin = '1;
        tick(); tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: rsp_valid=%b busy=%b req_ready=%b, want 0 0 0000",
                     rsp_valid, busy, req_ready);
        end
        checks++;
        if (rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_data: sum=%h cout=%b id=%0d, want 00 0 0", rsp_sum, rsp_cout, rsp_id);
        end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int lat;
        req_valid = 4'b0001;
        set_lane(0, 8'h5A, 8'h33, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_after_accept: req_ready=%b busy=%b want 0000 1", req_ready, busy);
        end
        wait_rsp(lat);
        checks++;
        if (lat !== WIDTH) begin
            errors++;
            $display("FAIL single_latency: got %0d edges want %0d", lat, WIDTH);
        end
        checks++;
        if (rsp_sum !== 8'h8D || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL single_result: sum=%h cout=%b id=%0d want 8d 0 0", rsp_sum, rsp_cout, rsp_id);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sum !== 8'h8D) begin
            errors++;
            $display("FAIL single_release: rsp_valid=%b busy=%b sum=%h want 0 0 8d", rsp_valid, busy, rsp_sum);
        end
    endtask

    task automatic test_carry();
        logic [WIDTH-1:0] s; logic co, ov; logic [IDW-1:0] id; int lat;
        run_one(2, 8'hFF, 8'h01, 1'b0, s, co, ov, id, lat);
        checks++;
        if (s !== 8'h00 || co !== 1'b1 || id !== 2'd2 || lat !== WIDTH) begin
            errors++;
            $display("FAIL carry_wrap: sum=%h cout=%b id=%0d lat=%0d want 00 1 2 8", s, co, id, lat);
        end
`ifdef SERIAL_ADD_SCHED_OVF_EN
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL carry_wrap_ovf: got %b want 0", ov); end
`endif
        run_one(2, 8'h7F, 8'h01, 1'b0, s, co, ov, id, lat);
        checks++;
        if (s !== 8'h80 || co !== 1'b0 || id !== 2'd2) begin
            errors++;
            $display("FAIL carry_signed: sum=%h cout=%b id=%0d want 80 0 2", s, co, id);
        end
`ifdef SERIAL_ADD_SCHED_OVF_EN
        checks++;
        if (ov !== 1'b1) begin errors++; $display("FAIL carry_signed_ovf: got %b want 1", ov); end
`endif
        run_one(3, 8'hFF, 8'hFF, 1'b1, s, co, ov, id, lat);
        checks++;
        if (s !== 8'hFF || co !== 1'b1 || id !== 2'd3) begin
            errors++;
            $display("FAIL carry_max: sum=%h cout=%b id=%0d want ff 1 3", s, co, id);
        end
`ifdef SERIAL_ADD_SCHED_OVF_EN
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL carry_max_ovf: got %b want 0", ov); end
`endif
    endtask

    task automatic test_round_robin();
        logic [WIDTH:0] exp;
        int lat, hs, last_hs, want;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            set_lane(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        req_valid = '1;
        rsp_ready = 1'b1;
        last_hs = -1;
        for (int n = 0; n < 5; n++) begin
            want = n % NUM_REQ;
            #1;
            checks++;
            if (req_ready !== NUM_REQ'(1 << want)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: req_ready=%b want one-hot %0d", n, req_ready, want);
            end
            exp = {1'b0, req_a[want*WIDTH +: WIDTH]} + {1'b0, req_b[want*WIDTH +: WIDTH]} +
                  (WIDTH+1)'(req_cin[want]);
            tick();
            wait_rsp(lat);
            checks++;
            if (rsp_id !== IDW'(want) || {rsp_cout, rsp_sum} !== exp || lat !== WIDTH) begin
                errors++;
                $display("FAIL rr_result[%0d]: id=%0d val=%h lat=%0d want %0d %h %0d",
                         n, rsp_id, {rsp_cout, rsp_sum}, lat, want, exp, WIDTH);
            end
            tick();
            hs = cyc;
            if (last_hs >= 0) begin
                checks++;
                if (hs - last_hs !== WIDTH + 2) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles want %0d", n, hs - last_hs, WIDTH + 2);
                end
            end
            last_hs = hs;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        // the 5th handshake leaves the DUT idle again; drain any accidental accept
        #1;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] s0; logic c0; logic [IDW-1:0] i0; int lat;
        req_valid = 4'b1000;
        set_lane(3, 8'hC3, 8'h4E, 1'b0);
        #1;
        tick();
        req_valid = '1;
        wait_rsp(lat);
        s0 = rsp_sum; c0 = rsp_cout; i0 = rsp_id;
        checks++;
        if (s0 !== 8'h11 || c0 !== 1'b1 || i0 !== 2'd3) begin
            errors++;
            $display("FAIL bp_result: sum=%h cout=%b id=%0d want 11 1 3", s0, c0, i0);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== s0 || rsp_cout !== c0 || rsp_id !== i0 ||
                req_ready !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b sum=%h cout=%b id=%0d rdy=%b busy=%b want 1 %h %b %0d 0000 1",
                         k, rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready, busy, s0, c0, i0);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sum !== s0 || rsp_id !== i0) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b sum=%h id=%0d want 0 0 %h %0d",
                     rsp_valid, busy, rsp_sum, rsp_id, s0, i0);
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] s; logic co, ov; logic [IDW-1:0] id; int lat; bit seen;
        req_valid = 4'b0010;
        set_lane(1, 8'hAA, 8'h55, 1'b1);
        #1;
        tick();
        req_valid = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
        seen = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            tick();
            if (rsp_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_rsp: got a response %b want none", seen);
        end
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_ptr: req_ready=%b want 0001", req_ready);
        end
        req_valid = '0;
        run_one(1, 8'h10, 8'h20, 1'b0, s, co, ov, id, lat);
        checks++;
        if (s !== 8'h30 || co !== 1'b0 || id !== 2'd1 || lat !== WIDTH) begin
            errors++;
            $display("FAIL midrst_retry: sum=%h cout=%b id=%0d lat=%0d want 30 0 1 8", s, co, id, lat);
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] v, want_rdy;
        logic [WIDTH:0]     exp;
        logic               exp_ovf;
        logic [WIDTH-1:0]   ea, eb;
        int mptr, g, lat, hold;
        do_reset();
        mptr = NUM_REQ - 1;
        for (int n = 0; n < 60; n++) begin
            v = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++)
                set_lane(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            req_valid = v;
            rsp_ready = 1'b0;
            #1;
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++)
                if (g < 0 && v[(mptr + k) % NUM_REQ]) g = (mptr + k) % NUM_REQ;
            want_rdy = (g < 0) ? '0 : NUM_REQ'(1 << g);
            checks++;
            if (req_ready !== want_rdy) begin
                errors++;
                $display("FAIL rand_grant[%0d]: req_ready=%b want %b (valid=%b)", n, req_ready, want_rdy, v);
            end
            if (g < 0) begin
                tick();
                continue;
            end
            ea  = req_a[g*WIDTH +: WIDTH];
            eb  = req_b[g*WIDTH +: WIDTH];
            exp = {1'b0, ea} + {1'b0, eb} + (WIDTH+1)'(req_cin[g]);
            exp_ovf = (ea[WIDTH-1] == eb[WIDTH-1]) && (exp[WIDTH-1] != ea[WIDTH-1]);
            tick();
            mptr = g;
            lat = 0;
            while (rsp_valid !== 1'b1 && lat < 60) begin
                req_valid = NUM_REQ'($urandom);
                for (int i = 0; i < NUM_REQ; i++)
                    set_lane(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
                #1;
                checks++;
                if (req_ready !== '0) begin
                    errors++;
                    $display("FAIL rand_busy_ready[%0d]: req_ready=%b want 0000", n, req_ready);
                end
                tick();
                lat++;
            end
            checks++;
            if (lat !== WIDTH || rsp_id !== IDW'(g) || {rsp_cout, rsp_sum} !== exp) begin
                errors++;
                $display("FAIL rand_result[%0d]: lat=%0d id=%0d val=%h want %0d %0d %h",
                         n, lat, rsp_id, {rsp_cout, rsp_sum}, WIDTH, g, exp);
            end
`ifdef SERIAL_ADD_SCHED_OVF_EN
            checks++;
            if (rsp_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL rand_ovf[%0d]: got %b want %b", n, rsp_ovf, exp_ovf);
            end
`endif
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                tick();
                checks++;
                if (rsp_valid !== 1'b1 || {rsp_cout, rsp_sum} !== exp || rsp_id !== IDW'(g)) begin
                    errors++;
                    $display("FAIL rand_hold[%0d]: valid=%b val=%h id=%0d want 1 %h %0d",
                             n, rsp_valid, {rsp_cout, rsp_sum}, rsp_id, exp, g);
                end
            end
            rsp_ready = 1'b1;
            req_valid = '1;
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL rand_hs_ready[%0d]: req_ready=%b want 0000", n, req_ready);
            end
            tick();
            rsp_ready = 1'b0;
            req_valid = '0;
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_release[%0d]: valid=%b busy=%b want 0 0", n, rsp_valid, busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_cin = '0;
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
